// File: rtl/game_pkg.sv
// Shared button types, bit map and default timing for the game/pixel pipeline.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;
    localparam int BTN_L = 4;

    // 36 MHz pixel clock: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period
    localparam int DEF_N_BTN           = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 360000;
    localparam int DEF_REPEAT_DELAY    = 18000000;
    localparam int DEF_REPEAT_PERIOD   = 3600000;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce FSM and auto-repeat; strobes are registered.
// Press/level rise DEBOUNCE_CYCLES+3 edges after the raw change is first sampled.
module button_channel
    import game_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int RCNT_W = $clog2(REPEAT_DELAY + 2);
    localparam int PCNT_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_FIRE = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RCNT_SAT  = RCNT_W'(REPEAT_DELAY + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REPEAT_PERIOD - 1);

    logic              sync1;
    logic              sync2;
    logic              s;
    btn_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [RCNT_W-1:0] rcnt;
    logic [PCNT_W-1:0] pcnt;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rcnt        <= '0;
            pcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state      <= HELD;
                        btn_level  <= 1'b1;
                        btn_press  <= 1'b1;
                        btn_repeat <= 1'b1;
                        rcnt       <= '0;
                        pcnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (REPEAT_EN) begin
                        // rcnt parks at DELAY+1 once the first repeat fires; pcnt paces the rest
                        if (rcnt == RCNT_FIRE) begin
                            btn_repeat <= 1'b1;
                            rcnt       <= RCNT_SAT;
                            pcnt       <= '0;
                        end else if (rcnt == RCNT_SAT) begin
                            if (pcnt == PCNT_LAST) begin
                                btn_repeat <= 1'b1;
                                pcnt       <= '0;
                            end else begin
                                pcnt <= pcnt + 1'b1;
                            end
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and auto-repeats N_BTN independent push-buttons (bit 0=c,1=u,2=d,3=r,4=l).
// Latency DEBOUNCE_CYCLES+3 edges per change; no backpressure, strobes are single-cycle.
module button_conditioner
    import game_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .pixel_clk   (pixel_clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, active-low pins.
module tb_button_conditioner;

    logic       pixel_clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [4:0] btn_repeat;

    int tests = 0;
    int fails = 0;

    always #5 pixel_clk = ~pixel_clk;

    button_conditioner #(
        .N_BTN           (5),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] acc;
        logic [1:0] acc2;
        logic       rep_exp;

        // reset state
        rst_n   = 1'b0;
        btn_raw = 5'b11111;
        #12;
        check("rst_level",   btn_level,   5'b00000);
        check("rst_press",   btn_press,   5'b00000);
        check("rst_release", btn_release, 5'b00000);
        check("rst_repeat",  btn_repeat,  5'b00000);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("idle_level", btn_level, 5'b00000);

        // clean press on bit 0: edge 1 samples, strobe visible after edge 7
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            check("press0_early", btn_press, 5'b00000);
            check("level0_early", btn_level, 5'b00000);
        end
        tick(1);
        check("press0",  btn_press,  5'b00001);
        check("repeat0", btn_repeat, 5'b00001);
        check("level0",  btn_level,  5'b00001);
        tick(1);
        check("press0_drop",  btn_press,  5'b00000);
        check("repeat0_drop", btn_repeat, 5'b00000);
        check("level0_hold",  btn_level,  5'b00001);

        // bounce on bit 1: 2-cycle pulses never reach the debounce count
        acc = 4'b0;
        for (int c = 0; c < 8; c++) begin
            btn_raw[1] = c[1];
            tick(1);
            acc |= {btn_press[1], btn_release[1], btn_repeat[1], btn_level[1]};
        end
        btn_raw[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            acc |= {btn_press[1], btn_release[1], btn_repeat[1], btn_level[1]};
        end
        check("bounce1", {1'b0, acc}, 5'b00000);

        // release glitch on bit 0 is ignored
        acc2 = 2'b0;
        btn_raw[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            acc2 |= {btn_release[0], ~btn_level[0]};
        end
        btn_raw[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            acc2 |= {btn_release[0], ~btn_level[0]};
        end
        check("rel0_glitch", {3'b0, acc2}, 5'b00000);

        // steady release on bit 0
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            check("rel0_early", btn_release, 5'b00000);
        end
        tick(1);
        check("rel0",       btn_release, 5'b00001);
        check("rel0_level", btn_level,   5'b00000);
        tick(1);
        check("rel0_drop",  btn_release, 5'b00000);

        // auto-repeat on bit 4; pin released after cycle 30, sync delay lets cycle 32 still repeat
        btn_raw[4] = 1'b0;
        tick(7);
        check("press4", btn_press, 5'b10000);
        for (int k = 1; k <= 45; k++) begin
            if (k == 31) btn_raw[4] = 1'b1;
            tick(1);
            rep_exp = (k <= 32) && ((k == 11) || (k >= 14 && ((k - 11) % 3) == 0));
            check("repeat4",  btn_repeat,  {rep_exp, 4'b0000});
            check("release4", btn_release, {(k == 37), 4'b0000});
            check("level4",   btn_level,   {(k < 37), 4'b0000});
        end

        // simultaneous press on bits 1 and 3
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b0;
        tick(6);
        check("sim_early", btn_press, 5'b00000);
        tick(1);
        check("sim_press",  btn_press,  5'b01010);
        check("sim_repeat", btn_repeat, 5'b01010);
        check("sim_level",  btn_level,  5'b01010);
        tick(1);
        check("sim_drop", btn_press, 5'b00000);

        // reset with bit 2 HELD and bit 0 in PRESS_WAIT
        btn_raw[2] = 1'b0;
        tick(7);
        check("press2",     btn_press, 5'b00100);
        check("pre_rst_lv", btn_level, 5'b01110);
        btn_raw[0] = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("arst_level",   btn_level,   5'b00000);
        check("arst_press",   btn_press,   5'b00000);
        check("arst_release", btn_release, 5'b00000);
        check("arst_repeat",  btn_repeat,  5'b00000);
        tick(2);
        check("rst_hold_level", btn_level, 5'b00000);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            check("post_rst_press",   btn_press,   5'b00000);
            check("post_rst_release", btn_release, 5'b00000);
        end
        tick(1);
        check("post_rst_press7",  btn_press,   5'b01111);
        check("post_rst_level7",  btn_level,   5'b01111);
        check("post_rst_release7", btn_release, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
